// File: rtl/clk_gen_pkg.sv
// Shared definitions for the programmable clock divider.
//   WIDTH_MAX : largest supported counter width
//   mode_t    : output mode select; encoding 3 is unnamed and behaves as DIV_PULSE
package clk_gen_pkg;

    localparam int unsigned WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        DIV_PULSE  = 2'd0,
        DIV_TOGGLE = 2'd1,
        PWM        = 2'd2
    } mode_t;

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of prog_clk_divider.
//   en, load, preset_val, duty_val, mode : driven by the controller (master)
//   cnt, co, sig_out                     : driven by the divider (slave)
interface prog_clk_divider_if #(
    parameter int unsigned WIDTH = 4
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] preset_val;
    logic [WIDTH-1:0] duty_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] cnt;
    logic             co;
    logic             sig_out;

    modport master (
        output en, load, preset_val, duty_val, mode,
        input  cnt, co, sig_out
    );

    modport slave (
        input  en, load, preset_val, duty_val, mode,
        output cnt, co, sig_out
    );

endinterface

// File: rtl/load_counter.sv
// Up-counter with synchronous preset, enable and wrap-around reload.
//   clk, rst    : clock, asynchronous active-high reset
//   en, load    : count enable, synchronous preset strobe (load has priority)
//   preset_val  : start value on load and reload value at terminal count
//   cnt         : current count
//   base        : preset value captured by the most recent load/reload
//   co          : combinational carry-out, en & (cnt == all-ones)
module load_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] preset_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] base,
    output logic             co
);

    logic at_max;

    assign at_max = (cnt == '1);
    assign co     = en & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            base <= '0;
        end else if (load) begin
            cnt  <= preset_val;
            base <= preset_val;
        end else if (en) begin
            if (at_max) begin
                // Reload from the live preset; the period restarts here.
                cnt  <= preset_val;
                base <= preset_val;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable clock divider / PWM generator.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of prog_clk_divider_if
//              en/load/preset_val/duty_val/mode in, cnt/co/sig_out out
// Divide ratio R = 2^WIDTH - preset_val. sig_out is a one-cycle pulse per
// period (DIV_PULSE), a 50% square wave of period 2R (DIV_TOGGLE), or a
// duty_val-cycle high pulse per period (PWM).
module prog_clk_divider
    import clk_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    prog_clk_divider_if.slave     bus
);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("prog_clk_divider: WIDTH out of range");
    end

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] phase;
    logic             toggle_q;
    logic             sig_q;

    load_counter #(.WIDTH(WIDTH)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.en),
        .load       (bus.load),
        .preset_val (bus.preset_val),
        .cnt        (bus.cnt),
        .base       (base),
        .co         (bus.co)
    );

    // Position within the current period, 0 .. R-1 (modulo 2^WIDTH).
    assign phase = bus.cnt - base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= 1'b0;
            sig_q    <= 1'b0;
        end else if (bus.load) begin
            toggle_q <= 1'b0;
            sig_q    <= 1'b0;
        end else if (bus.en) begin
            toggle_q <= toggle_q ^ bus.co;
            case (bus.mode)
                DIV_TOGGLE: sig_q <= toggle_q ^ bus.co;  // track the new toggle value
                PWM:        sig_q <= (phase < bus.duty_val);
                default:    sig_q <= bus.co;
            endcase
        end else if (bus.mode != DIV_TOGGLE && bus.mode != PWM) begin
            // Pulse mode drops to 0 while idle; other modes hold.
            sig_q <= 1'b0;
        end
    end

    assign bus.sig_out = sig_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_clk_divider_if #(.WIDTH(W)) bus_a ();
    prog_clk_divider_if #(.WIDTH(W)) bus_b ();

    assign bus_b.en = bus_a.co;

    prog_clk_divider #(.WIDTH(W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    prog_clk_divider #(.WIDTH(W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: period start value and position within the period.
    int m_base;
    int m_phase;
    bit m_tog;
    bit m_sig;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        return (m_base + m_phase) % M;
    endfunction

    function automatic bit m_co();
        return bus_a.en && (m_phase == (M - m_base) - 1);
    endfunction

    task automatic model_reset();
        m_base  = 0;
        m_phase = 0;
        m_tog   = 1'b0;
        m_sig   = 1'b0;
    endtask

    task automatic model_edge();
        int r;
        bit tc;
        r = M - m_base;
        if (bus_a.load) begin
            m_base  = int'(bus_a.preset_val);
            m_phase = 0;
            m_tog   = 1'b0;
            m_sig   = 1'b0;
        end else if (bus_a.en) begin
            tc = (m_phase == r - 1);
            case (int'(bus_a.mode))
                1:       m_sig = m_tog ^ tc;
                2:       m_sig = (m_phase < int'(bus_a.duty_val));
                default: m_sig = tc;
            endcase
            if (tc) begin
                m_tog   = !m_tog;
                m_base  = int'(bus_a.preset_val);
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end else if (bus_a.mode == 2'd0 || bus_a.mode == 2'd3) begin
            m_sig = 1'b0;
        end
    endtask

    task automatic drive(input bit en, input bit load, input int preset, input int duty, input int mode);
        bus_a.en         = en;
        bus_a.load       = load;
        bus_a.preset_val = preset[W-1:0];
        bus_a.duty_val   = duty[W-1:0];
        bus_a.mode       = mode[1:0];
        #1;
        check_eq("co", bus_a.co, m_co());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("cnt", bus_a.cnt, m_cnt());
        check_eq("sig_out", bus_a.sig_out, m_sig);
    endtask

    task automatic step(input bit en, input bit load, input int preset, input int duty, input int mode);
        drive(en, load, preset, duty, mode);
        tick();
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        check_eq("rst_cnt", bus_a.cnt, 0);
        check_eq("rst_sig", bus_a.sig_out, 0);
        check_eq("rst_co", bus_a.co, 0);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        int lowrun;
        int first_k;
        int second_k;
        int n_casc;
        int duties[3];
        int exp_highs[3];
        duties    = '{3, 0, 12};
        exp_highs = '{6, 0, 20};

        rst              = 1'b1;
        bus_a.en         = 1'b0;
        bus_a.load       = 1'b0;
        bus_a.preset_val = '0;
        bus_a.duty_val   = '0;
        bus_a.mode       = 2'd0;
        bus_b.load       = 1'b0;
        bus_b.preset_val = '0;
        bus_b.duty_val   = '0;
        bus_b.mode       = 2'd0;
        #3;
        check_eq("init_cnt", bus_a.cnt, 0);
        check_eq("init_sig", bus_a.sig_out, 0);
        check_eq("init_co", bus_a.co, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Pulse mode, preset 10: one pulse every 6 cycles.
        step(1, 1, 10, 0, 0);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 10, 0, 0);
            highs += int'(bus_a.sig_out);
        end
        check_eq("pulse_highs", highs, 2);

        // Toggle mode, preset 12: period 8, then a 3-cycle stall.
        step(1, 1, 12, 0, 1);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 12, 0, 1);
            highs += int'(bus_a.sig_out);
        end
        check_eq("toggle_highs", highs, 8);
        for (int i = 0; i < 2; i++) step(1, 0, 12, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 12, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 12, 0, 1);

        // PWM, R = 10, several duty values.
        step(1, 1, 6, 3, 2);
        for (int d = 0; d < 3; d++) begin
            highs = 0;
            for (int i = 0; i < 20; i++) begin
                step(1, 0, 6, duties[d], 2);
                highs += int'(bus_a.sig_out);
            end
            check_eq("pwm_highs", highs, exp_highs[d]);
        end

        // R = 1: carry on every enabled cycle.
        step(1, 1, 15, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 15, 0, 0);
        drive(1, 0, 15, 0, 0);
        check_eq("co_r1", bus_a.co, 1);
        tick();

        // Load coinciding with terminal count wins.
        step(1, 1, 10, 0, 0);
        for (int i = 0; i < 8 && m_cnt() != 15; i++) step(1, 0, 10, 0, 0);
        check_eq("reach_tc", bus_a.cnt, 15);
        step(1, 1, 5, 0, 0);
        check_eq("load_tc_cnt", bus_a.cnt, 5);
        check_eq("load_tc_sig", bus_a.sig_out, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-count; counting restarts from 0.
        pulse_reset();
        lowrun = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            if (bus_a.co) break;
            lowrun++;
            tick();
        end
        check_eq("co_first_after_rst", lowrun, 15);
        tick();

        // Cascade: second counter enabled by the first carry.
        @(posedge clk);
        model_edge();
        pulse_reset();
        first_k  = -1;
        second_k = -1;
        n_casc   = 0;
        for (int k = 0; k < 600; k++) begin
            drive(1, 0, 0, 0, 0);
            if (bus_b.co) begin
                n_casc++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
            tick();
        end
        check_eq("casc_first", first_k, 255);
        check_eq("casc_count", n_casc, 2);
        check_eq("casc_gap", second_k - first_k, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
